// File: rtl/instr_mem_loadable.sv
// ---------------------------------------------------------------------------
// instr_mem_loadable
//
// Loadable instruction memory for the IF stage. After reset the block sits in
// LOAD and accepts one program word per loader beat into an internal RAM.
// Loading ends on ld_last or when the RAM is full. The block then moves to RUN
// and serves registered fetches with stall, flush and out-of-range detection.
// Unloaded or out-of-range addresses return NOP_WORD.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   ld_valid     loader word valid
//   ld_data      loader word
//   ld_last      final program word (qualified by ld_valid)
//   ld_ready     loader words accepted (LOAD state)
//   ld_start     in RUN: restart loading from address 0
//   fetch_en     fetch enable; low stalls and holds the fetch outputs
//   flush        invalidate the fetch outputs
//   pc           fetch address
//   instr_out    fetched instruction (registered)
//   instr_valid  instr_out holds a fetched word
//   pc_err       fetched pc was out of range (registered with instr_out)
//   run          program loaded, fetch active
//   load_count   number of words loaded (0..DEPTH)
// ---------------------------------------------------------------------------
module instr_mem_loadable #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 8,
    parameter int                PC_W     = 16,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              ld_start,
    input  logic              fetch_en,
    input  logic              flush,
    input  logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid,
    output logic              pc_err,
    output logic              run,
    output logic [ADDR_W:0]   load_count
);

    localparam int              DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [ADDR_W:0]   wptr_q;
    logic [ADDR_W:0]   load_count_q;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_p1;
    logic              hit_p1;
    logic              vld_p1;
    logic              err_p1;

    logic              beat;
    logic              load_done;
    logic              fetch_go;
    logic              pc_hi_zero;
    logic              in_range;
    logic [ADDR_W-1:0] rd_addr;

    // Loader handshake and fetch qualification
    assign beat       = ld_valid && (state_q == S_LOAD);
    // A full buffer ends the load even when the loader never sends ld_last.
    assign load_done  = ld_last || (wptr_q == LAST_PTR);

    assign rd_addr    = pc[ADDR_W-1:0];
    // Upper pc bits must be zero; a wide pc is never folded onto the RAM.
    assign pc_hi_zero = ((pc >> ADDR_W) == '0);
    assign in_range   = pc_hi_zero && ({1'b0, rd_addr} < load_count_q);

    // ld_start and flush both take precedence over a fetch in the same cycle.
    assign fetch_go   = (state_q == S_RUN) && !ld_start && !flush && fetch_en;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and state-decoded outputs
    always_comb begin
        state_d  = state_q;
        ld_ready = 1'b0;
        run      = 1'b0;
        case (state_q)
            S_LOAD: begin
                ld_ready = 1'b1;
                if (beat && load_done) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                run = 1'b1;
                if (ld_start) begin
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // Write pointer and loaded-word count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q       <= '0;
            load_count_q <= '0;
        end else if (beat) begin
            wptr_q       <= wptr_q + 1'b1;
            load_count_q <= wptr_q + 1'b1;
        end else if ((state_q == S_RUN) && ld_start) begin
            wptr_q       <= '0;
            load_count_q <= '0;
        end
    end

    // RAM: write during LOAD, synchronous read during RUN. The two never
    // overlap, so there is no read/write collision to resolve. No reset here
    // so the array and read register map onto block RAM.
    always_ff @(posedge clk) begin
        if (beat) begin
            mem[wptr_q[ADDR_W-1:0]] <= ld_data;
        end
        if (fetch_go) begin
            rd_data_p1 <= mem[rd_addr];
        end
    end

    // Fetch status, stage 1. A stall leaves all three flags untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_p1 <= 1'b0;
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
        end else if (state_q == S_RUN) begin
            if (ld_start || flush) begin
                hit_p1 <= 1'b0;
                vld_p1 <= 1'b0;
                err_p1 <= 1'b0;
            end else if (fetch_en) begin
                hit_p1 <= in_range;
                vld_p1 <= 1'b1;
                err_p1 <= !in_range;
            end
        end
    end

    // hit_p1 masks the un-reset RAM read register, so instr_out shows
    // NOP_WORD after reset, flush, reload or an out-of-range fetch.
    assign instr_out   = hit_p1 ? rd_data_p1 : NOP_WORD;
    assign instr_valid = vld_p1;
    assign pc_err      = err_p1;
    assign load_count  = load_count_q;

endmodule

// File: doc/instr_mem_loadable.md
Name: instr_mem_loadable

Overview:
Parametrised, loadable successor to the fixed-program instruction ROM.
- After reset, a loader port fills an internal RAM with the program, one word per accepted beat.
- The block then serves registered instruction fetches to the pipeline's IF stage, with stall, flush and out-of-range detection.
- Unloaded or out-of-range addresses return a configurable NOP word, matching the ROM's default-0 behaviour.

Parameters:
DATA_W, 16, instruction word width in bits
ADDR_W, 8, RAM address width; DEPTH = 2**ADDR_W words
PC_W, 16, width of the incoming pc
NOP_WORD, 0, word returned for unloaded/out-of-range fetches and on reset/flush

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
ld_valid  input  1  loader word valid
ld_data  input  DATA_W  loader word
ld_last  input  1  marks final word of program (qualified by ld_valid)
ld_ready  output  1  block accepts loader words (high only in LOAD)
ld_start  input  1  in RUN: restart loading from address 0
fetch_en  input  1  fetch enable; low = stall
flush  input  1  invalidate fetch output
pc  input  PC_W  fetch address
instr_out  output  DATA_W  registered instruction
instr_valid  output  1  instr_out holds a fetched word
pc_err  output  1  registered with instr_out: fetched pc was out of range
run  output  1  program loaded, fetch active
load_count  output  ADDR_W+1  number of words loaded (0..DEPTH)

Behaviour:
- Reset (rst=0, asynchronous):
  - state=LOAD, wptr=0, load_count=0.
  - instr_out=NOP_WORD, instr_valid=0, pc_err=0, run=0.
  - RAM contents are not cleared.
- FSM states: LOAD, RUN.
  - ld_ready=(state==LOAD); run=(state==RUN). Both are decoded from the state register, with no combinational path from inputs.
- LOAD:
  - Beat = ld_valid & ld_ready. On a beat: mem[wptr]<=ld_data, wptr<=wptr+1, load_count<=wptr+1.
  - Transition to RUN in the cycle after a beat where ld_last=1 OR wptr==DEPTH-1. The buffer-full case forces RUN even without ld_last.
  - ld_valid with ld_last=1 on an empty program (first beat) is legal: load_count=1.
  - fetch_en, flush, pc and ld_start are ignored; instr_valid stays 0.
- RUN, priority per cycle: ld_start > flush > fetch_en.
  - ld_start=1: next state LOAD; wptr=0, load_count=0, instr_valid=0, instr_out=NOP_WORD, pc_err=0.
  - flush=1: instr_valid<=0, instr_out<=NOP_WORD, pc_err<=0. A flush in the same cycle as fetch_en discards that fetch.
  - fetch_en=1: one-cycle latency; pc sampled at edge N, data at outputs after edge N.
    - in_range = (pc[PC_W-1:ADDR_W]==0) && (pc[ADDR_W-1:0] < load_count).
    - instr_out<=in_range ? mem[pc[ADDR_W-1:0]] : NOP_WORD; pc_err<=~in_range; instr_valid<=1.
  - fetch_en=0 (stall): instr_out, instr_valid and pc_err hold their values.
- The read port is synchronous (block-RAM inferable). No write occurs in RUN, so there is no read/write collision.
- Arithmetic:
  - wptr is ADDR_W+1 bits wide and never exceeds DEPTH.
  - The load_count comparison is unsigned.
  - pc wider than ADDR_W is range-checked on its upper bits, never truncated silently.
- Reset mid-load or mid-fetch: immediate return to reset values. The program must be reloaded before run rises again.

Test Plan:
- Reset then load 4 words (0x963C, 0x920F, 0xB67B, 0xAECE, ld_last on 4th) -> ld_ready=1 for 4 cycles, then run=1, ld_ready=0, load_count=4.
- Fetch pc=0..3 back-to-back with fetch_en=1 -> instr_out shows 0x963C,0x920F,0xB67B,0xAECE one cycle after each pc, instr_valid=1, pc_err=0.
- Fetch pc=4 (unloaded) and pc=0x0100 (upper bits set) -> instr_out=NOP_WORD(0), pc_err=1, instr_valid=1.
- Stall and flush:
  - fetch pc=1, then fetch_en=0 with pc changing for 3 cycles -> instr_out holds 0x920F.
  - flush with fetch_en=1 -> instr_valid=0, instr_out=0.
- Overflow load:
  - stream DEPTH=256 words with no ld_last -> run=1 after the 256th beat, load_count=256.
  - fetch pc=255 -> last word.
- ld_start in RUN -> next cycle ld_ready=1, run=0, load_count=0, instr_valid=0.
  - reload 2 words -> pc=1 returns new word, pc=2 -> NOP with pc_err=1.
- Assert rst low mid-load (after 2 beats) -> outputs at reset values asynchronously; after release, load_count=0 and ld_ready=1.
